// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: holds one instruction between execute and
// write-back, waits for the data-SRAM response of a load, aligns/extends the
// load data, exports a bypass view to decode, and discards responses that
// belong to loads killed by a pipeline flush.
module mem_stage_lsu #(
    parameter int unsigned SIDE_W = 80
) (
    input  logic              clk,
    input  logic              reset,

    // execute -> memory handshake and payload
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [31:0]       es_pc,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [31:0]       es_alu_result,
    input  logic              es_mem_req,
    input  logic [4:0]        es_load_op,
    input  logic [SIDE_W-1:0] es_side,

    // data SRAM response channel
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,

    // write-back side
    input  logic              ws_allowin,
    input  logic              ws_flush_pipe,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [SIDE_W-1:0] ms_side,
    output logic [31:0]       ms_final_result,

    // bypass / interlock view for decode
    output logic              ms_fwd_valid,
    output logic [4:0]        ms_fwd_dest,
    output logic [31:0]       ms_fwd_data,
    output logic              ms_fwd_stall
);

    // Load-op one-hot bit positions: {ld.w, ld.hu, ld.h, ld.bu, ld.b}
    localparam int unsigned OP_B  = 0;
    localparam int unsigned OP_BU = 1;
    localparam int unsigned OP_H  = 2;
    localparam int unsigned OP_HU = 3;
    localparam int unsigned OP_W  = 4;

    // Stage state
    logic              ms_valid_q,  ms_valid_d;
    logic              got_q,       got_d;
    logic [31:0]       buf_q,       buf_d;
    logic [1:0]        cancel_cnt_q, cancel_cnt_d;

    // Registered payload
    logic [31:0]       pc_q,         pc_d;
    logic              gr_we_q,      gr_we_d;
    logic [4:0]        dest_q,       dest_d;
    logic [31:0]       alu_result_q, alu_result_d;
    logic              mem_req_q,    mem_req_d;
    logic [4:0]        load_op_q,    load_op_d;
    logic [SIDE_W-1:0] side_q,       side_d;

    // Combinational helpers
    logic              rsp_mine;
    logic              ms_ready_go;
    logic              accept;
    logic              cancel_inc;
    logic              cancel_dec;
    logic [31:0]       load_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       final_result;

    // Response ownership, handshake and bypass signals
    always_comb begin
        rsp_mine       = data_sram_data_ok & (cancel_cnt_q == 2'd0) &
                         ms_valid_q & mem_req_q & ~got_q;
        ms_ready_go    = ~mem_req_q | got_q | rsp_mine;
        ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
        accept         = ms_allowin & es_to_ms_valid & ~ws_flush_pipe;
        ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ws_flush_pipe;
        ms_fwd_stall   = ms_valid_q & mem_req_q & ~ms_ready_go;
        ms_fwd_valid   = ms_valid_q & gr_we_q;
        // A flushed load still waiting for its response leaves one orphan
        // response in flight; an owned response in the flush cycle is
        // consumed here and therefore needs no cancel.
        cancel_inc     = ws_flush_pipe & ms_valid_q & mem_req_q & ~got_q & ~rsp_mine;
        cancel_dec     = data_sram_data_ok & (cancel_cnt_q != 2'd0);
    end

    // Next-state for valid, payload, response buffer and cancel counter
    always_comb begin
        ms_valid_d   = ms_valid_q;
        got_d        = got_q;
        buf_d        = buf_q;
        cancel_cnt_d = cancel_cnt_q;
        pc_d         = pc_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        alu_result_d = alu_result_q;
        mem_req_d    = mem_req_q;
        load_op_d    = load_op_q;
        side_d       = side_q;

        if (ws_flush_pipe) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (accept) begin
            pc_d         = es_pc;
            gr_we_d      = es_gr_we;
            dest_d       = es_dest;
            alu_result_d = es_alu_result;
            mem_req_d    = es_mem_req;
            load_op_d    = es_load_op;
            side_d       = es_side;
        end

        // Buffered data only matters for the instruction that owns it, so a
        // flush or a newly accepted instruction always starts with it empty.
        if (ws_flush_pipe || accept) begin
            got_d = 1'b0;
        end else if (rsp_mine && !ws_allowin) begin
            got_d = 1'b1;
        end

        if (rsp_mine && !ws_allowin) begin
            buf_d = data_sram_rdata;
        end

        case ({cancel_inc, cancel_dec})
            2'b10:   cancel_cnt_d = (cancel_cnt_q == 2'd3) ? 2'd3 : cancel_cnt_q + 2'd1;
            2'b01:   cancel_cnt_d = cancel_cnt_q - 2'd1;
            default: cancel_cnt_d = cancel_cnt_q;
        endcase
    end

    // State and payload registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            got_q        <= 1'b0;
            buf_q        <= 32'd0;
            cancel_cnt_q <= 2'd0;
            pc_q         <= 32'd0;
            gr_we_q      <= 1'b0;
            dest_q       <= 5'd0;
            alu_result_q <= 32'd0;
            mem_req_q    <= 1'b0;
            load_op_q    <= 5'd0;
            side_q       <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            got_q        <= got_d;
            buf_q        <= buf_d;
            cancel_cnt_q <= cancel_cnt_d;
            pc_q         <= pc_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            alu_result_q <= alu_result_d;
            mem_req_q    <= mem_req_d;
            load_op_q    <= load_op_d;
            side_q       <= side_d;
        end
    end

    // Load data selection, alignment and extension
    always_comb begin
        load_data = got_q ? buf_q : data_sram_rdata;

        case (alu_result_q[1:0])
            2'd0:    byte_sel = load_data[7:0];
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            default: byte_sel = load_data[31:24];
        endcase

        half_sel = alu_result_q[1] ? load_data[31:16] : load_data[15:0];

        final_result = alu_result_q;
        if (load_op_q[OP_W]) begin
            final_result = load_data;
        end else if (load_op_q[OP_HU]) begin
            final_result = {16'd0, half_sel};
        end else if (load_op_q[OP_H]) begin
            final_result = {{16{half_sel[15]}}, half_sel};
        end else if (load_op_q[OP_BU]) begin
            final_result = {24'd0, byte_sel};
        end else if (load_op_q[OP_B]) begin
            final_result = {{24{byte_sel[7]}}, byte_sel};
        end
    end

    // Registered payload and bypass outputs
    always_comb begin
        ms_pc           = pc_q;
        ms_gr_we        = gr_we_q;
        ms_dest         = dest_q;
        ms_side         = side_q;
        ms_final_result = final_result;
        ms_fwd_dest     = dest_q;
        ms_fwd_data     = final_result;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu: ALU pass-through, load alignment,
// flush cancellation, write-back back-pressure buffering and reset mid-wait.
module tb_mem_stage_lsu;

    localparam int unsigned SIDE_W = 80;

    localparam logic [4:0] LD_B  = 5'b00001;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b10000;

    logic              clk;
    logic              reset;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [31:0]       es_pc;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [31:0]       es_alu_result;
    logic              es_mem_req;
    logic [4:0]        es_load_op;
    logic [SIDE_W-1:0] es_side;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              ws_allowin;
    logic              ws_flush_pipe;
    logic              ms_to_ws_valid;
    logic [31:0]       ms_pc;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [SIDE_W-1:0] ms_side;
    logic [31:0]       ms_final_result;
    logic              ms_fwd_valid;
    logic [4:0]        ms_fwd_dest;
    logic [31:0]       ms_fwd_data;
    logic              ms_fwd_stall;

    int vecCount  = 0;
    int missCount = 0;

    mem_stage_lsu #(.SIDE_W(SIDE_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_gr_we          (es_gr_we),
        .es_dest           (es_dest),
        .es_alu_result     (es_alu_result),
        .es_mem_req        (es_mem_req),
        .es_load_op        (es_load_op),
        .es_side           (es_side),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ws_flush_pipe     (ws_flush_pipe),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_side           (ms_side),
        .ms_final_result   (ms_final_result),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_fwd_stall      (ms_fwd_stall)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] dest,
                                 input logic [31:0] alu, input logic memReq,
                                 input logic [4:0] op);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_gr_we       = 1'b1;
        es_dest        = dest;
        es_alu_result  = alu;
        es_mem_req     = memReq;
        es_load_op     = op;
        es_side        = {16'hA5A5, pc, ~pc};
    endtask

    // Issue a load, let it wait waitCycles, then return rdata and check the result
    task automatic runLoad(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input int waitCycles, input logic [31:0] rdata,
                           input logic [31:0] expected);
        applyStimulus(32'h0000_3000 + addr, 5'd7, addr, 1'b1, op);
        @(negedge clk);
        checkOutput({tag, "_allowin"}, ms_allowin, 1);
        nextCycle();
        es_to_ms_valid = 1'b0;
        repeat (waitCycles) begin
            @(negedge clk);
            checkOutput({tag, "_stall"}, ms_fwd_stall, 1);
            checkOutput({tag, "_holdvalid"}, ms_to_ws_valid, 0);
            nextCycle();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        @(negedge clk);
        checkOutput({tag, "_stall_done"}, ms_fwd_stall, 0);
        checkOutput({tag, "_to_ws"}, ms_to_ws_valid, 1);
        checkOutput({tag, "_result"}, ms_final_result, expected);
        checkOutput({tag, "_fwd_data"}, ms_fwd_data, expected);
        nextCycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_pc             = 32'd0;
        es_gr_we          = 1'b0;
        es_dest           = 5'd0;
        es_alu_result     = 32'd0;
        es_mem_req        = 1'b0;
        es_load_op        = 5'd0;
        es_side           = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ws_allowin        = 1'b1;
        ws_flush_pipe     = 1'b0;

        repeat (2) nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_to_ws", ms_to_ws_valid, 0);
        checkOutput("rst_fwd_valid", ms_fwd_valid, 0);
        checkOutput("rst_fwd_stall", ms_fwd_stall, 0);
        checkOutput("rst_allowin", ms_allowin, 1);
        checkOutput("rst_pc", ms_pc, 0);
        checkOutput("rst_result", ms_final_result, 0);
        nextCycle();

        // ALU op passes through in one cycle
        applyStimulus(32'h0000_1000, 5'd5, 32'h0000_1234, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("alu_allowin", ms_allowin, 1);
        nextCycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        checkOutput("alu_to_ws", ms_to_ws_valid, 1);
        checkOutput("alu_result", ms_final_result, 32'h0000_1234);
        checkOutput("alu_stall", ms_fwd_stall, 0);
        checkOutput("alu_fwd_valid", ms_fwd_valid, 1);
        checkOutput("alu_fwd_dest", ms_fwd_dest, 5);
        checkOutput("alu_pc", ms_pc, 32'h0000_1000);
        checkOutput("alu_side", ms_side[31:0], 32'hFFFF_EFFF);
        checkOutput("alu_side_hi", ms_side[79:48], 32'hA5A5_0000);
        nextCycle();
        @(negedge clk);
        checkOutput("alu_drained", ms_to_ws_valid, 0);
        nextCycle();

        // Load alignment and extension
        runLoad("ldb",  LD_B,  32'h0000_0103, 3, 32'h80FF_0000, 32'hFFFF_FF80);
        runLoad("ldbu", LD_BU, 32'h0000_0103, 1, 32'h80FF_0000, 32'h0000_0080);
        runLoad("ldhu", LD_HU, 32'h0000_0102, 0, 32'h80FF_0000, 32'h0000_80FF);
        runLoad("ldh",  LD_H,  32'h0000_0100, 2, 32'h1234_8001, 32'hFFFF_8001);
        runLoad("ldb1", LD_B,  32'h0000_0101, 0, 32'h0000_7F00, 32'h0000_007F);
        runLoad("ldw",  LD_W,  32'h0000_0104, 1, 32'hA1B2_C3D4, 32'hA1B2_C3D4);

        // Flush while a load waits: its later response must be dropped
        applyStimulus(32'h0000_2000, 5'd3, 32'h0000_0100, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        checkOutput("fl_wait_stall", ms_fwd_stall, 1);
        nextCycle();
        ws_flush_pipe = 1'b1;
        @(negedge clk);
        checkOutput("fl_to_ws", ms_to_ws_valid, 0);
        nextCycle();
        ws_flush_pipe = 1'b0;
        @(negedge clk);
        checkOutput("fl_killed", ms_fwd_valid, 0);
        checkOutput("fl_allowin", ms_allowin, 1);
        applyStimulus(32'h0000_2004, 5'd4, 32'h0000_0104, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        @(negedge clk);
        checkOutput("fl_drop_to_ws", ms_to_ws_valid, 0);
        checkOutput("fl_drop_stall", ms_fwd_stall, 1);
        nextCycle();
        data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("fl_own_to_ws", ms_to_ws_valid, 1);
        checkOutput("fl_own_result", ms_final_result, 32'h1234_5678);
        nextCycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;

        // Response under write-back back-pressure is buffered and held
        applyStimulus(32'h0000_4000, 5'd9, 32'h0000_0300, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_BABE;
        @(negedge clk);
        checkOutput("bp_first_to_ws", ms_to_ws_valid, 1);
        checkOutput("bp_first_allowin", ms_allowin, 0);
        nextCycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD_0BAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_to_ws", ms_to_ws_valid, 1);
            checkOutput("bp_hold_result", ms_final_result, 32'hCAFE_BABE);
            checkOutput("bp_hold_stall", ms_fwd_stall, 0);
            checkOutput("bp_hold_allowin", ms_allowin, 0);
            nextCycle();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        checkOutput("bp_drain_result", ms_final_result, 32'hCAFE_BABE);
        checkOutput("bp_drain_allowin", ms_allowin, 1);
        nextCycle();
        data_sram_rdata = 32'd0;
        @(negedge clk);
        checkOutput("bp_drained", ms_to_ws_valid, 0);
        nextCycle();

        // Flush in the same cycle as the owned response: nothing left to cancel
        applyStimulus(32'h0000_5000, 5'd2, 32'h0000_0400, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid    = 1'b0;
        ws_flush_pipe     = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0055;
        @(negedge clk);
        checkOutput("fo_to_ws", ms_to_ws_valid, 0);
        nextCycle();
        ws_flush_pipe     = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        @(negedge clk);
        checkOutput("fo_killed", ms_fwd_valid, 0);
        nextCycle();
        runLoad("fo_next", LD_W, 32'h0000_0500, 0, 32'h0000_0066, 32'h0000_0066);

        // Reset while a load waits with a cancel pending
        applyStimulus(32'h0000_6000, 5'd1, 32'h0000_0600, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid = 1'b0;
        ws_flush_pipe  = 1'b1;
        nextCycle();
        ws_flush_pipe = 1'b0;
        applyStimulus(32'h0000_7000, 5'd1, 32'h0000_0700, 1'b1, LD_W);
        nextCycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        checkOutput("rs_pre_stall", ms_fwd_stall, 1);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rs_to_ws", ms_to_ws_valid, 0);
        checkOutput("rs_fwd_valid", ms_fwd_valid, 0);
        checkOutput("rs_fwd_stall", ms_fwd_stall, 0);
        checkOutput("rs_allowin", ms_allowin, 1);
        checkOutput("rs_pc", ms_pc, 0);
        checkOutput("rs_dest", ms_dest, 0);
        checkOutput("rs_gr_we", ms_gr_we, 0);
        nextCycle();
        runLoad("rs_next", LD_W, 32'h0000_0800, 0, 32'h0000_0077, 32'h0000_0077);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
